// File: rtl/icache_pkg.sv
// Shared field widths and FSM encoding for the instruction cache.
package icache_pkg;

    localparam int TAG_W    = 4;
    localparam int INDEX_W  = 4;
    localparam int OFFSET_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        FILLED = 2'd2
    } state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache: one combinational
// read port, one word write port, a line-fill strobe and a flash-invalidate.
module icache_array #(
    parameter int TAG_W    = 4,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2,
    parameter int DATA_W   = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                fill_en,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic                flush
);
    import icache_pkg::*;

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << (INDEX_W + OFFSET_W);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [WORDS];

    // Valid bits: cleared by reset or flush, set when a line fill completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            valid_q <= '0;
        else if (flush)
            valid_q <= '0;
        else if (fill_en)
            valid_q[wr_index] <= 1'b1;
    end

    // Tag and data arrays carry no reset; an entry only matters once valid.
    always_ff @(posedge clock) begin
        if (wr_en)
            data_mem[{wr_index, wr_offset}] <= wr_data;
        if (fill_en)
            tag_mem[wr_index] <= fill_tag;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between IM and the fetch stage.
// A miss stalls the core (PReady=0) while the whole line is fetched from IM
// in offset order, then the re-lookup hits.
//
//   state  | meaning
//   IDLE   | lookup; hit serves PData, miss latches tag/index
//   REFILL | one IM read per SysReady beat, offset 0 upward
//   FILLED | line now valid; one bubble before the re-lookup
module icache #(
    parameter int ADDR_W   = 10,
    parameter int INDEX_W  = icache_pkg::INDEX_W,
    parameter int OFFSET_W = icache_pkg::OFFSET_W,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              PStrobe,
    input  logic [ADDR_W-1:0] PAddress,
    output logic              PReady,
    output logic [DATA_W-1:0] PData,
    input  logic              Invalidate,
    output logic              SysStrobe,
    output logic [ADDR_W-1:0] SysAddress,
    input  logic [DATA_W-1:0] SysData,
    input  logic              SysReady
);
    import icache_pkg::*;

    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_LSB = INDEX_W + OFFSET_W;

    state_t              state, state_nxt;
    logic [TAG_W-1:0]    tag_q;
    logic [INDEX_W-1:0]  idx_q;
    logic [OFFSET_W-1:0] cnt_q;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_data;
    logic                hit, miss, beat, last_beat, fill_en;

    assign req_tag = PAddress[ADDR_W-1:LINE_LSB];
    assign req_idx = PAddress[LINE_LSB-1:OFFSET_W];
    assign req_off = PAddress[OFFSET_W-1:0];

    assign hit       = PStrobe & rd_valid & (rd_tag == req_tag);
    assign miss      = (state == IDLE) & PStrobe & ~hit;
    assign beat      = (state == REFILL) & SysReady;
    assign last_beat = beat & (cnt_q == '1);
    // An invalidate on the final beat must leave the line invalid.
    assign fill_en   = last_beat & ~Invalidate;

    icache_array #(
        .TAG_W    (TAG_W),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .DATA_W   (DATA_W)
    ) u_array (
        .clock     (clock),
        .reset     (reset),
        .rd_index  (req_idx),
        .rd_offset (req_off),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (beat),
        .wr_index  (idx_q),
        .wr_offset (cnt_q),
        .wr_data   (SysData),
        .fill_en   (fill_en),
        .fill_tag  (tag_q),
        .flush     (Invalidate)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Latched miss address and refill beat counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
        end else if (miss) begin
            tag_q <= req_tag;
            idx_q <= req_idx;
            cnt_q <= '0;
        end else if (beat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        PReady    = 1'b0;
        SysStrobe = 1'b0;
        case (state)
            IDLE: begin
                PReady = hit | ~PStrobe;
                if (miss)
                    state_nxt = REFILL;
            end
            REFILL: begin
                SysStrobe = 1'b1;
                if (Invalidate)
                    state_nxt = IDLE;
                else if (last_beat)
                    state_nxt = FILLED;
            end
            FILLED: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // The core is held in reset too, so nothing is stalling it.
        if (reset)
            PReady = 1'b1;
    end

    assign SysAddress = SysStrobe ? {tag_q, idx_q, cnt_q} : '0;
    assign PData      = ((state == IDLE) && hit) ? rd_data : '0;

endmodule
